wave_sequencer: RTL and testbench

Programmable controller that sequences a single-bit waveform output from a loaded pattern word. It accepts a configuration (pattern, length, bit period, pass count) over a valid/ready handshake, then plays the pattern LSB-first at the configured rate for the configured number of passes, with abort and completion signalling. It generalises the fixed-pattern waveform generators in the generators tree into a reusable, reconfigurable source for stimulus and clocking blocks.

---
 rtl/wave_sequencer.sv | 178 +++++++++++++++++
 tb/tb_wave_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wave_sequencer
// Purpose  : Plays a loaded pattern word LSB-first as a single-bit waveform.
//            Each bit lasts (div+1) cycles, and the pattern is played
//            (last+1) bits long for 'repeat' passes (0 = until stopped).
// Ports    : clock          - rising-edge clock
//            reset          - synchronous, active-low reset
//            io_cfg_valid   - configuration offered
//            io_cfg_ready   - configuration can be accepted (IDLE only)
//            io_cfg_pattern - pattern bits, bit 0 played first
//            io_cfg_last    - index of the last bit played
//            io_cfg_div     - bit period minus one, in cycles
//            io_cfg_repeat  - number of passes, 0 = free-running
//            io_stop        - abort the current run (level-sampled)
//            io_wave        - registered waveform output
//            io_strobe      - pulse in the first cycle of each played bit
//            io_busy        - high while playing
//            io_done        - one-cycle pulse after a normally completed run
// Revision : 1.0 - initial release
// ============================================================================
module wave_sequencer #(
    parameter int PAT_W = 16,
    parameter int DIV_W = 8,
    parameter int REP_W = 8,
    localparam int LEN_W = $clog2(PAT_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_cfg_valid,
    output logic             io_cfg_ready,
    input  logic [PAT_W-1:0] io_cfg_pattern,
    input  logic [LEN_W-1:0] io_cfg_last,
    input  logic [DIV_W-1:0] io_cfg_div,
    input  logic [REP_W-1:0] io_cfg_repeat,
    input  logic             io_stop,
    output logic             io_wave,
    output logic             io_strobe,
    output logic             io_busy,
    output logic             io_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_last;
    logic [DIV_W-1:0] r_div;
    logic [REP_W-1:0] r_repeat;
    logic [LEN_W-1:0] r_index;
    logic [DIV_W-1:0] r_divcnt;
    logic [REP_W-1:0] r_pass;
    logic             r_wave;
    logic             r_strobe;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic [LEN_W-1:0] w_index_next;
    logic [REP_W-1:0] w_pass_next;
    logic             w_bit_end;
    logic             w_pass_end;
    logic             w_run_end;

    always_comb begin
        w_index_next = r_index + 1'b1;
        w_pass_next  = r_pass + 1'b1;
        w_bit_end    = (r_divcnt == r_div);
        w_pass_end   = w_bit_end && (r_index == r_last);
        // A run with repeat == 0 never ends by itself; the pass counter
        // simply wraps.
        w_run_end    = w_pass_end && (r_repeat != '0) && (w_pass_next == r_repeat);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_last    <= '0;
            r_div     <= '0;
            r_repeat  <= '0;
            r_index   <= '0;
            r_divcnt  <= '0;
            r_pass    <= '0;
            r_wave    <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wave   <= 1'b0;
                    r_strobe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                    if (io_cfg_valid && r_ready) begin
                        r_pattern <= io_cfg_pattern;
                        r_last    <= io_cfg_last;
                        r_div     <= io_cfg_div;
                        r_repeat  <= io_cfg_repeat;
                        r_index   <= '0;
                        r_divcnt  <= '0;
                        r_pass    <= '0;
                        r_state   <= ST_RUN;
                        // Outputs are registered, so bit 0 is presented in
                        // the cycle right after the handshake.
                        r_wave    <= io_cfg_pattern[0];
                        r_strobe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (io_stop) begin
                        // Stop takes priority even over a final-bit boundary.
                        r_state  <= ST_IDLE;
                        r_wave   <= 1'b0;
                        r_strobe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                    end else if (w_run_end) begin
                        r_state  <= ST_DONE;
                        r_pass   <= w_pass_next;
                        r_divcnt <= '0;
                        r_index  <= '0;
                        r_wave   <= 1'b0;
                        r_strobe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_pass_end) begin
                        r_pass   <= w_pass_next;
                        r_divcnt <= '0;
                        r_index  <= '0;
                        r_wave   <= r_pattern[0];
                        r_strobe <= 1'b1;
                    end else if (w_bit_end) begin
                        r_divcnt <= '0;
                        r_index  <= w_index_next;
                        r_wave   <= r_pattern[w_index_next];
                        r_strobe <= 1'b1;
                    end else begin
                        r_divcnt <= r_divcnt + 1'b1;
                        r_wave   <= r_pattern[r_index];
                        r_strobe <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_wave   <= 1'b0;
                    r_strobe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign io_cfg_ready = r_ready;
    assign io_wave      = r_wave;
    assign io_strobe    = r_strobe;
    assign io_busy      = r_busy;
    assign io_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_sequencer
// Purpose  : Self-checking bench for wave_sequencer: a table of complete runs
//            with hand-computed waveforms, plus directed sequences for stop,
//            reconfiguration attempts during a run, and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_sequencer;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_pattern;
    logic [3:0]  cfg_last;
    logic [7:0]  cfg_div;
    logic [7:0]  cfg_repeat;
    logic        stop;
    logic        wave;
    logic        strobe;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    wave_sequencer #(.PAT_W(16), .DIV_W(8), .REP_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_cfg_valid   (cfg_valid),
        .io_cfg_ready   (cfg_ready),
        .io_cfg_pattern (cfg_pattern),
        .io_cfg_last    (cfg_last),
        .io_cfg_div     (cfg_div),
        .io_cfg_repeat  (cfg_repeat),
        .io_stop        (stop),
        .io_wave        (wave),
        .io_strobe      (strobe),
        .io_busy        (busy),
        .io_done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] pattern;
        logic [3:0]  last;
        logic [7:0]  div;
        logic [7:0]  rep;
        logic [63:0] exp_wave;    // bit k = io_wave in busy cycle k
        logic [63:0] exp_strobe;  // bit k = io_strobe in busy cycle k
        int          n_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge; sampling and driving both happen 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic offer(input logic [15:0] p, input logic [3:0] l,
                         input logic [7:0] d, input logic [7:0] r);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_last    = l;
        cfg_div     = d;
        cfg_repeat  = r;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        cfg_valid = 1'b0;
        cfg_pattern = '0;
        cfg_last = '0;
        cfg_div = '0;
        cfg_repeat = '0;
        stop = 1'b0;

        vecs[0] = '{16'h000A, 4'd4,  8'd0, 8'd1, 64'h0A,    64'h1F,   5};
        vecs[1] = '{16'h0005, 4'd2,  8'd2, 8'd2, 64'h38FC7, 64'h9249, 18};
        vecs[2] = '{16'h0001, 4'd0,  8'd1, 8'd3, 64'h3F,    64'h15,   6};
        vecs[3] = '{16'h0006, 4'd2,  8'd1, 8'd1, 64'h3C,    64'h15,   6};
        vecs[4] = '{16'h8001, 4'd15, 8'd0, 8'd1, 64'h8001,  64'hFFFF, 16};

        tick();
        tick();
        check("rst_wave",   {31'd0, wave},      32'd0);
        check("rst_strobe", {31'd0, strobe},    32'd0);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_done",   {31'd0, done},      32'd0);
        check("rst_ready",  {31'd0, cfg_ready}, 32'd1);
        reset = 1'b1;
        tick();

        // ---------------- table-driven complete runs ----------------
        for (int v = 0; v < 5; v++) begin
            wait_ready();
            offer(vecs[v].pattern, vecs[v].last, vecs[v].div, vecs[v].rep);
            tick();
            cfg_valid = 1'b0;
            for (int k = 0; k < vecs[v].n_busy; k++) begin
                check($sformatf("v%0d_busy%0d", v, k),   {31'd0, busy},   32'd1);
                check($sformatf("v%0d_wave%0d", v, k),   {31'd0, wave},   {31'd0, vecs[v].exp_wave[k]});
                check($sformatf("v%0d_strobe%0d", v, k), {31'd0, strobe}, {31'd0, vecs[v].exp_strobe[k]});
                check($sformatf("v%0d_nodone%0d", v, k), {31'd0, done},   32'd0);
                tick();
            end
            check($sformatf("v%0d_done", v),       {31'd0, done},      32'd1);
            check($sformatf("v%0d_done_busy", v),  {31'd0, busy},      32'd0);
            check($sformatf("v%0d_done_wave", v),  {31'd0, wave},      32'd0);
            check($sformatf("v%0d_done_ready", v), {31'd0, cfg_ready}, 32'd0);
            tick();
            check($sformatf("v%0d_post_done", v),  {31'd0, done},      32'd0);
            check($sformatf("v%0d_post_ready", v), {31'd0, cfg_ready}, 32'd1);
        end

        // ---------------- repeat=0, stop after 20 busy cycles ----------------
        wait_ready();
        offer(16'h00F0, 4'd7, 8'd0, 8'd0);
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("free_wave%0d", k), {31'd0, wave}, {31'd0, ((k % 8) >= 4)});
            check($sformatf("free_busy%0d", k), {31'd0, busy}, 32'd1);
            check($sformatf("free_done%0d", k), {31'd0, done}, 32'd0);
            if (k == 19) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        check("free_stop_busy",  {31'd0, busy},      32'd0);
        check("free_stop_wave",  {31'd0, wave},      32'd0);
        check("free_stop_ready", {31'd0, cfg_ready}, 32'd1);
        check("free_stop_done",  {31'd0, done},      32'd0);
        tick();
        check("free_stop_done2", {31'd0, done},      32'd0);

        // ---------------- cfg_valid held during RUN is ignored ----------------
        wait_ready();
        offer(16'h0005, 4'd2, 8'd0, 8'd1);
        tick();
        offer(16'hFFFF, 4'd15, 8'd3, 8'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ign_ready%0d", k), {31'd0, cfg_ready}, 32'd0);
            check($sformatf("ign_wave%0d", k),  {31'd0, wave},      {31'd0, (k != 1)});
            tick();
        end
        check("ign_done", {31'd0, done}, 32'd1);
        cfg_valid = 1'b0;
        tick();
        check("ign_ready_after", {31'd0, cfg_ready}, 32'd1);
        check("ign_idle_busy",   {31'd0, busy},      32'd0);

        // ---------------- stop on the final-bit boundary ----------------
        wait_ready();
        offer(16'h0003, 4'd1, 8'd0, 8'd1);
        tick();
        cfg_valid = 1'b0;
        check("fb_wave0", {31'd0, wave}, 32'd1);
        tick();
        check("fb_wave1", {31'd0, wave}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("fb_done",  {31'd0, done},      32'd0);
        check("fb_busy",  {31'd0, busy},      32'd0);
        check("fb_ready", {31'd0, cfg_ready}, 32'd1);
        tick();
        check("fb_done2", {31'd0, done},      32'd0);

        // ---------------- reset mid-run, then immediate reconfiguration ----------------
        wait_ready();
        offer(16'h00FF, 4'd7, 8'd0, 8'd0);
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mr_wave",   {31'd0, wave},      32'd0);
        check("mr_strobe", {31'd0, strobe},    32'd0);
        check("mr_busy",   {31'd0, busy},      32'd0);
        check("mr_done",   {31'd0, done},      32'd0);
        check("mr_ready",  {31'd0, cfg_ready}, 32'd1);
        offer(16'h000A, 4'd4, 8'd0, 8'd1);
        tick();
        cfg_valid = 1'b0;
        check("mr_new_busy",   {31'd0, busy},   32'd1);
        check("mr_new_wave0",  {31'd0, wave},   32'd0);
        check("mr_new_strobe", {31'd0, strobe}, 32'd1);
        tick();
        check("mr_new_wave1",  {31'd0, wave},   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
